// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encodings, parity selectors,
// supported oversampling ratios, default byte width and a vote helper.
package uart_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // 2-of-3 majority
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Serial line, frame configuration and parallel result of the UART
// receive deframer. master = line/config driver, slave = deframer.
interface uart_rx_deframer_if
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESC_W    = 6
);
   logic                  RX_IN;
   logic [PRESC_W-1:0]    Prescale;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  par_err;
   logic                  stp_err;

   modport master (
      output RX_IN, Prescale, PAR_EN, PAR_TYP,
      input  P_DATA, Data_Valid, par_err, stp_err
   );

   modport slave (
      input  RX_IN, Prescale, PAR_EN, PAR_TYP,
      output P_DATA, Data_Valid, par_err, stp_err
   );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and bit counter for the UART receiver.
// clr marks the current cycle as edge 0 of a new frame (so the next
// cycle reads edge 1); en advances the count. wrap flags the last
// oversample cycle of the current bit.
module uart_rx_edge_bit_cnt #(
   parameter int PRESC_W = 6,
   parameter int BIT_W   = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               clr,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic [BIT_W-1:0]   bit_cnt,
   output logic               wrap
);
   logic [PRESC_W-1:0] edge_base;
   logic [BIT_W-1:0]   bit_base;

   // effective count this cycle: zero on the frame-start cycle
   always_comb begin
      edge_base = clr ? '0 : edge_cnt;
      bit_base  = clr ? '0 : bit_cnt;
      wrap      = (edge_base == presc - 1'b1);
   end

   // advance edge count, wrap at presc-1 and bump the bit count
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (clr || en) begin
         if (wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_base + 1'b1;
         end else begin
            edge_cnt <= edge_base + 1'b1;
            bit_cnt  <= bit_base;
         end
      end
   end
endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizes RX_IN, detects the start edge,
// samples each bit mid-cell, shifts data LSB-first, checks parity and
// stop, and strobes Data_Valid with the byte on good frames.
// Optional macro UART_RX_MAJORITY_EN: 3-sample majority vote per bit
// instead of a single mid-cell sample (timing identical either way).
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESC_W    = 6
) (
   input logic               CLK,
   input logic               RST,
   uart_rx_deframer_if.slave bus
);
   localparam int BIT_W = $clog2(DATA_WIDTH + 4);

   rx_state_e             state;
   logic                  rx_m, rx_s, rx_d;
   logic [PRESC_W-1:0]    presc_q, half, cnt_presc;
   logic                  par_en_q, par_typ_q;
   logic [DATA_WIDTH-1:0] shreg;
   logic [PRESC_W-1:0]    edge_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  wrap, start_det, at_smp, smp_bit;

   // two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= bus.RX_IN;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   // falling edge only counts from a high line, so a stuck-low line after
   // a stop error cannot retrigger until it returns high
   assign start_det = (state == ST_IDLE) && rx_d && !rx_s;
   // the frame-start cycle has not latched Prescale yet
   assign cnt_presc = start_det ? bus.Prescale : presc_q;
   assign half      = presc_q >> 1;
   assign at_smp    = (edge_cnt == half + 1'b1);

   uart_rx_edge_bit_cnt #(.PRESC_W(PRESC_W), .BIT_W(BIT_W)) u_cnt (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (start_det),
      .en       (state != ST_IDLE),
      .presc    (cnt_presc),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt),
      .wrap     (wrap)
   );

`ifdef UART_RX_MAJORITY_EN
   logic smp_a, smp_b;

   // capture the two samples leading up to the decision point
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         smp_a <= 1'b1;
         smp_b <= 1'b1;
      end else begin
         if (edge_cnt == half - 1'b1) smp_a <= rx_s;
         if (edge_cnt == half)        smp_b <= rx_s;
      end
   end

   assign smp_bit = maj3(smp_a, smp_b, rx_s);
`else
   assign smp_bit = rx_s;
`endif

   // frame FSM; every non-idle state also exits on a counter wrap so an
   // unsupported Prescale that never reaches the sample point cannot hang it
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state          <= ST_IDLE;
         presc_q        <= '0;
         par_en_q       <= 1'b0;
         par_typ_q      <= 1'b0;
         shreg          <= '0;
         bus.P_DATA     <= '0;
         bus.Data_Valid <= 1'b0;
         bus.par_err    <= 1'b0;
         bus.stp_err    <= 1'b0;
      end else begin
         bus.Data_Valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_det) begin
                  state       <= ST_START;
                  presc_q     <= bus.Prescale;
                  par_en_q    <= bus.PAR_EN;
                  par_typ_q   <= bus.PAR_TYP;
                  bus.par_err <= 1'b0;
                  bus.stp_err <= 1'b0;
               end
            end
            ST_START: begin
               if (at_smp && smp_bit) state <= ST_IDLE;
               else if (wrap)         state <= ST_DATA;
            end
            ST_DATA: begin
               if (at_smp) shreg <= {smp_bit, shreg[DATA_WIDTH-1:1]};
               if (wrap && bit_cnt == BIT_W'(DATA_WIDTH))
                  state <= par_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
               if (at_smp && (smp_bit != (^shreg ^ (par_typ_q == PAR_ODD))))
                  bus.par_err <= 1'b1;
               if (wrap) state <= ST_STOP;
            end
            ST_STOP: begin
               // leave at mid-stop so a following start edge is not missed
               if (at_smp) begin
                  state <= ST_IDLE;
                  if (!smp_bit) begin
                     bus.stp_err <= 1'b1;
                  end else if (!bus.par_err) begin
                     bus.Data_Valid <= 1'b1;
                     bus.P_DATA     <= shreg;
                  end
               end else if (wrap) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: table of frames plus
// hand-written back-to-back, glitch, spike and mid-frame reset sequences.
// Expected bytes go into a queue when driven and are popped on each strobe.
module tb_uart_rx_deframer;
   import uart_pkg::*;

   logic CLK;
   logic RST;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   dv_cnt = 0;
   int   last_dv = 0;
   int   prev_dv = 0;
   int   start_cyc = 0;
   logic [7:0] exp_q[$];

   uart_rx_deframer_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

   uart_rx_deframer #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         p;
      logic       pe;
      logic       pt;
      logic [7:0] d;
      logic       bad_par;
      logic       stop_v;
      logic       exp_dv;
      logic       exp_pe;
      logic       exp_se;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard: every strobe must match the oldest expected byte
   always @(negedge CLK) begin
      if (RST && bus.Data_Valid) begin
         dv_cnt++;
         prev_dv = last_dv;
         last_dv = cyc;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got P_DATA 0x%0h, expected no strobe", bus.P_DATA);
         end else begin
            check("strobe_P_DATA", 32'(bus.P_DATA), 32'(exp_q.pop_front()));
         end
      end
   end

   // one bit cell of p cycles; spike_at flips the line for one cycle
   task automatic drive_bit(input int p, input logic v, input int spike_at);
      for (int m = 0; m < p; m++) begin
         bus.RX_IN = (m == spike_at) ? ~v : v;
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send_frame(input int p, input logic pe, input logic pt, input logic [7:0] d,
                             input logic bad_par, input logic stop_v, input int spike_bit);
      logic pbit;
      bus.Prescale = 6'(p);
      bus.PAR_EN   = pe;
      bus.PAR_TYP  = pt;
      start_cyc    = cyc;
      drive_bit(p, 1'b0, -1);
      for (int i = 0; i < 8; i++) drive_bit(p, d[i], (i == spike_bit) ? p / 2 + 1 : -1);
      if (pe) begin
         pbit = (^d) ^ pt ^ bad_par;
         drive_bit(p, pbit, -1);
      end
      drive_bit(p, stop_v, -1);
   endtask

   initial begin
      int         d0;
      int         k;
      logic [7:0] last_good;

      vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8,  1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{16, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{32, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{8,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      RST          = 1'b0;
      bus.RX_IN    = 1'b1;
      bus.Prescale = 6'(PRESC_8);
      bus.PAR_EN   = 1'b0;
      bus.PAR_TYP  = PAR_EVEN;
      last_good    = 8'h00;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset_P_DATA", 32'(bus.P_DATA), 32'h0);
      check("reset_Data_Valid", 32'(bus.Data_Valid), 32'h0);
      check("reset_par_err", 32'(bus.par_err), 32'h0);
      check("reset_stp_err", 32'(bus.stp_err), 32'h0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      drive_bit(8, 1'b1, -1);

      // table of single frames
      for (int i = 0; i < 8; i++) begin
         d0 = dv_cnt;
         if (vecs[i].exp_dv) exp_q.push_back(vecs[i].d);
         send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d,
                    vecs[i].bad_par, vecs[i].stop_v, -1);
         drive_bit(vecs[i].p, 1'b1, -1);
         drive_bit(vecs[i].p, 1'b1, -1);
         check($sformatf("v%0d_strobes", i), 32'(dv_cnt - d0), 32'(vecs[i].exp_dv));
         if (vecs[i].exp_dv) begin
            last_good = vecs[i].d;
            // stop sample at edge p/2+1 of bit (9+pe); 2 sync flops + 1 register
            k = (9 + int'(vecs[i].pe)) * vecs[i].p + vecs[i].p / 2 + 1;
            check($sformatf("v%0d_strobe_cycle", i), 32'(last_dv - start_cyc), 32'(k + 3));
         end
         check($sformatf("v%0d_par_err", i), 32'(bus.par_err), 32'(vecs[i].exp_pe));
         check($sformatf("v%0d_stp_err", i), 32'(bus.stp_err), 32'(vecs[i].exp_se));
         check($sformatf("v%0d_P_DATA", i), 32'(bus.P_DATA), 32'(last_good));
      end

      // back-to-back frames, no idle gap
      d0 = dv_cnt;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(PRESC_32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, -1);
      send_frame(PRESC_32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, -1);
      drive_bit(PRESC_32, 1'b1, -1);
      check("b2b_strobes", 32'(dv_cnt - d0), 32'd2);
      check("b2b_spacing", 32'(last_dv - prev_dv), 32'd320);
      check("b2b_P_DATA", 32'(bus.P_DATA), 32'hFF);
      last_good = 8'hFF;

      // short low glitch must be dropped in START
      d0 = dv_cnt;
      bus.Prescale = 6'(PRESC_16);
      bus.RX_IN = 1'b0;
      repeat (3) begin @(posedge CLK); #1; end
      bus.RX_IN = 1'b1;
      drive_bit(48, 1'b1, -1);
      check("glitch_strobes", 32'(dv_cnt - d0), 32'd0);
      check("glitch_par_err", 32'(bus.par_err), 32'h0);
      check("glitch_stp_err", 32'(bus.stp_err), 32'h0);
      check("glitch_P_DATA", 32'(bus.P_DATA), 32'(last_good));
      exp_q.push_back(8'h99);
      send_frame(PRESC_16, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, -1);
      drive_bit(PRESC_16, 1'b1, -1);
      check("post_glitch_strobes", 32'(dv_cnt - d0), 32'd1);
      last_good = 8'h99;

`ifdef UART_RX_MAJORITY_EN
      // one-cycle inversion exactly on the decision sample of data bit 3
      d0 = dv_cnt;
      exp_q.push_back(8'h5A);
      send_frame(PRESC_16, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 3);
      drive_bit(PRESC_16, 1'b1, -1);
      check("spike_strobes", 32'(dv_cnt - d0), 32'd1);
      check("spike_P_DATA", 32'(bus.P_DATA), 32'h5A);
`endif

      // reset during data bit 4 of 0x81, then a clean 0x7E
      d0 = dv_cnt;
      bus.Prescale = 6'(PRESC_8);
      bus.PAR_EN   = 1'b0;
      drive_bit(PRESC_8, 1'b0, -1);
      for (int i = 0; i < 4; i++) drive_bit(PRESC_8, (8'h81 >> i) & 8'h01, -1);
      drive_bit(2, 1'b0, -1);
      RST = 1'b0;
      bus.RX_IN = 1'b1;
      @(negedge CLK);
      check("midrst_P_DATA", 32'(bus.P_DATA), 32'h0);
      check("midrst_Data_Valid", 32'(bus.Data_Valid), 32'h0);
      check("midrst_par_err", 32'(bus.par_err), 32'h0);
      check("midrst_stp_err", 32'(bus.stp_err), 32'h0);
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      drive_bit(16, 1'b1, -1);
      exp_q.push_back(8'h7E);
      send_frame(PRESC_8, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, -1);
      drive_bit(16, 1'b1, -1);
      check("midrst_strobes", 32'(dv_cnt - d0), 32'd1);
      check("midrst_P_DATA_after", 32'(bus.P_DATA), 32'h7E);

      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
